// File: rtl/cog_ctrx.sv
// cog_ctrx: multi-channel cog counter block.
// Each channel has a CTR (mode/pin selects), FRQ and PHS register. The PHS
// accumulator carries an extra carry bit above WIDTH. Channels run NCO, duty,
// period-capture, one-shot and pin-triggered accumulate modes. The ALU writes
// the registers through sel/set* and reads PHS/CAP back. All channel pin
// drivers are OR-ed onto one shared pin bus.
module cog_ctrx #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32,
    parameter int PINS     = 32
) (
    input  logic                                            clk_cog,
    input  logic                                            rst,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
    input  logic                                            setctr,
    input  logic                                            setfrq,
    input  logic                                            setphs,
    input  logic [31:0]                                     data,
    input  logic [PINS-1:0]                                 pin_in,
    output logic [CHANNELS*(WIDTH+1)-1:0]                   phs,
    output logic [CHANNELS*WIDTH-1:0]                       cap,
    output logic [CHANNELS-1:0]                             evt,
    output logic [PINS-1:0]                                 pin_out
);

    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PB = $clog2(PINS);

    // Per-channel pin drive vectors, merged onto pin_out below.
    logic [PINS-1:0] drive [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // Only the mode and pin-select fields of CTR affect anything, so
            // only those are kept.
            logic [4:0]       mode_reg;
            logic [PB-1:0]    apin_reg;
            logic [PB-1:0]    bpin_reg;
            logic [WIDTH-1:0] frq_reg;
            logic [WIDTH-1:0] cap_reg;
            logic [WIDTH-1:0] cap_next;
            logic [WIDTH:0]   phs_reg;
            logic [WIDTH:0]   phs_next;
            logic [WIDTH:0]   sum;
            logic [1:0]       dly_reg;
            logic [1:0]       dly_next;
            logic             evt_reg;
            logic             evt_next;
            logic             wr_hit;
            logic             trig;
            logic             outa;
            logic             outb;
            logic [3:0]       lut;
            logic [PINS-1:0]  drive_v;

            // An out-of-range sel matches no channel, so that write is dropped.
            assign wr_hit = (sel == SW'(gi));
            assign sum    = {1'b0, phs_reg[WIDTH-1:0]} + {1'b0, frq_reg};
            assign lut    = mode_reg[3:0];

            // Trigger decode for the pin-driven modes (8-31).
            always_comb begin
                trig = 1'b0;
                if (mode_reg[4]) begin
                    // Logic modes: mode[3:0] is a truth table indexed by {B, A}.
                    trig = lut[dly_reg];
                end else if (mode_reg[3]) begin
                    case (mode_reg[2:1])
                        2'b00:   trig = dly_reg[0];
                        2'b01:   trig = (dly_reg == 2'b01);
                        2'b10:   trig = !dly_reg[0];
                        default: trig = (dly_reg == 2'b10);
                    endcase
                end
            end

            // Next-state logic for the accumulator, capture, pin delay and event.
            always_comb begin
                phs_next = phs_reg;
                cap_next = cap_reg;
                evt_next = 1'b0;
                dly_next = dly_reg;
                if (mode_reg >= 5'd5) begin
                    dly_next = {mode_reg[4] ? pin_in[bpin_reg] : dly_reg[0], pin_in[apin_reg]};
                end
                if (mode_reg >= 5'd1 && mode_reg <= 5'd4) begin
                    phs_next = sum;
                    evt_next = sum[WIDTH];
                end else if (mode_reg == 5'd5) begin
                    if (dly_reg == 2'b01) begin
                        // Restart the count from zero so cap reads
                        // (period - 1) * frq at the next rising edge.
                        cap_next = phs_reg[WIDTH-1:0];
                        phs_next = '0;
                        evt_next = 1'b1;
                    end else begin
                        phs_next = sum;
                    end
                end else if (mode_reg == 5'd6) begin
                    phs_next[WIDTH] = 1'b0;
                    if (phs_reg[WIDTH-1:0] != '0) begin
                        if (phs_reg[WIDTH-1:0] > frq_reg) begin
                            phs_next[WIDTH-1:0] = phs_reg[WIDTH-1:0] - frq_reg;
                        end else begin
                            phs_next[WIDTH-1:0] = '0;
                            evt_next            = 1'b1;
                        end
                    end
                end else if (mode_reg >= 5'd8 && trig) begin
                    phs_next = sum;
                    evt_next = sum[WIDTH];
                end
                // A PHS write wins over any update, and the load itself is silent.
                if (setphs && wr_hit) begin
                    phs_next = {1'b0, data[WIDTH-1:0]};
                    evt_next = 1'b0;
                end
            end

            // Channel state registers. A CTR or FRQ write takes effect next cycle.
            always_ff @(posedge clk_cog) begin
                if (rst) begin
                    mode_reg <= '0;
                    apin_reg <= '0;
                    bpin_reg <= '0;
                    frq_reg  <= '0;
                    phs_reg  <= '0;
                    cap_reg  <= '0;
                    dly_reg  <= '0;
                    evt_reg  <= 1'b0;
                end else begin
                    phs_reg <= phs_next;
                    cap_reg <= cap_next;
                    dly_reg <= dly_next;
                    evt_reg <= evt_next;
                    if (setctr && wr_hit) begin
                        mode_reg <= data[30:26];
                        apin_reg <= data[PB-1:0];
                        bpin_reg <= data[9 +: PB];
                    end
                    if (setfrq && wr_hit) begin
                        frq_reg <= data[WIDTH-1:0];
                    end
                end
            end

            // Pin outputs from registered state only.
            always_comb begin
                outa = 1'b0;
                outb = 1'b0;
                case (mode_reg)
                    5'd1: outa = phs_reg[WIDTH-1];
                    5'd2: begin
                        outa = phs_reg[WIDTH-1];
                        outb = !phs_reg[WIDTH-1];
                    end
                    5'd3: outa = phs_reg[WIDTH];
                    5'd4: begin
                        outa = phs_reg[WIDTH];
                        outb = !phs_reg[WIDTH];
                    end
                    5'd6: outa = (phs_reg[WIDTH-1:0] != '0);
                    5'd9, 5'd11, 5'd13, 5'd15: outb = !dly_reg[0];
                    default: ;
                endcase
            end

            // Route outa to pin apin and outb to pin bpin.
            always_comb begin
                drive_v = '0;
                if (outa) drive_v[apin_reg] = 1'b1;
                if (outb) drive_v[bpin_reg] = 1'b1;
            end

            assign drive[gi]                        = drive_v;
            assign phs[gi*(WIDTH+1) +: (WIDTH+1)]   = phs_reg;
            assign cap[gi*WIDTH +: WIDTH]           = cap_reg;
            assign evt[gi]                          = evt_reg;
        end
    endgenerate

    // OR every channel's drive vector onto the shared pin bus.
    always_comb begin
        pin_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pin_out = pin_out | drive[i];
        end
    end

endmodule
